// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller:
// scan-phase enum, segment bit positions and the hex font.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        DEAD = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } scan_state_t;

    // Bit positions inside the {dp,g,f,e,d,c,b,a} segment byte
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba patterns, index 0 at the LSB end
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
// Output polarity is applied by the parent.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_pattern
);

    always_comb begin
        o_pattern                = '0;
        o_pattern[SEG_G:SEG_A]   = HEX_FONT[i_nibble];
        o_pattern[SEG_DP]        = i_dp;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous loading,
// leading-zero blanking, brightness PWM and dead time. Optional SEG_SCAN_BLINK_EN adds per-digit blink.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SLOT_BITS   = 10,
    parameter int DEAD_CYCLES = 16,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   digit,
    output logic [7:0]              segment,
    output logic                    frame_start
);

    localparam int                   IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [SLOT_BITS-1:0] DEAD_END = SLOT_BITS'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic                 POL      = (ACTIVE_LOW != 0);

    logic [SLOT_BITS-1:0]    r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val, r_disp_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
    logic                    r_frame;
    logic [NUM_DIGITS-1:0]   r_digit;
    logic [7:0]              r_seg;
    scan_state_t             r_state, w_state;

    logic                    w_slot_wrap, w_frame_wrap;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic [7:0]              w_pat;
    logic [NUM_DIGITS-1:0]   w_lead;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_blank;
    logic                    w_blink_off;

    assign w_slot_wrap  = (r_cnt == CNT_MAX);
    assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);

    // Counters and frame-synchronous pending -> display transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_frame <= w_frame_wrap;
            if (w_slot_wrap)
                r_idx <= w_frame_wrap ? '0 : r_idx + 1'b1;
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp;
            end
            if (w_frame_wrap) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0] r_pend_blink, r_disp_blink;
    logic [5:0]            r_fcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_blink <= '0;
            r_disp_blink <= '0;
            r_fcnt       <= '0;
        end else begin
            if (load)
                r_pend_blink <= blink_mask;
            if (w_frame_wrap) begin
                r_disp_blink <= r_pend_blink;
                r_fcnt       <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_blink_off = r_disp_blink[r_idx] && r_fcnt[5];
`else
    assign w_blink_off = 1'b0;
`endif

    // Phase FSM: once OFF, ON can only be re-entered after the slot wraps
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= DEAD;
        else
            r_state <= w_state;
    end

    always_comb begin
        w_state = OFF;
        if (r_cnt < DEAD_END)
            w_state = DEAD;
        else if (((r_state != OFF) || (r_cnt == '0)) &&
                 (r_cnt[SLOT_BITS-1 -: 4] < brightness))
            w_state = ON;
    end

    // w_lead[i]: digit i and all higher digits are zero with no dp set
    always_comb begin
        logic v_run;
        v_run  = 1'b1;
        w_lead = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_run     = v_run && (r_disp_val[i*4 +: 4] == 4'h0) && !r_disp_dp[i];
            w_lead[i] = v_run;
        end
    end

    assign w_nib    = r_disp_val[{r_idx, 2'b00} +: 4];
    assign w_dp     = r_disp_dp[r_idx];
    assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    assign w_blank  = (lz_blank && (r_idx != '0) && w_lead[r_idx]) || w_blink_off;

    seg_hex_decode u_decode (
        .i_nibble  (w_nib),
        .i_dp      (w_dp),
        .o_pattern (w_pat)
    );

    // Output register stage with pin polarity applied
    always_ff @(posedge clk) begin
        if (reset || (w_state != ON)) begin
            r_digit <= {NUM_DIGITS{POL}};
            r_seg   <= {8{POL}};
        end else begin
            r_digit <= POL ? ~w_onehot : w_onehot;
            r_seg   <= w_blank ? {8{POL}} : (POL ? ~w_pat : w_pat);
        end
    end

    assign digit       = r_digit;
    assign segment     = r_seg;
    assign frame_start = r_frame;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller; next generation of the fixed 8-digit scan driver used on the board bring-up controller.
- Time-multiplexes NUM_DIGITS hex digits onto shared cathodes.
- Adds the following over the fixed driver:
  - tear-free frame-synchronous value loading
  - leading-zero blanking
  - 4-bit brightness PWM
  - anti-ghost dead time
- Sits between game/score logic and the board's digit/segment pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..16).
- SLOT_BITS, 10, log2 of clock cycles per digit slot (slot length 2**SLOT_BITS).
- DEAD_CYCLES, 16, cycles at start of each slot with all digits off (< 2**SLOT_BITS / 16).
- ACTIVE_LOW, 1, 1 = digit and segment pins active-low; 0 = active-high.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- value  input  4*NUM_DIGITS  hex nibbles; nibble i shown on digit i; digit 0 is rightmost
- dp  input  NUM_DIGITS  decimal point per digit
- load  input  1  capture value/dp into pending register
- lz_blank  input  1  suppress leading zeros
- brightness  input  4  duty level; 0 = off, 15 = maximum
- digit  output  NUM_DIGITS  one-hot digit enable (polarity per ACTIVE_LOW)
- segment  output  8  {dp,g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
- frame_start  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (synchronous, active-high):
  - slot counter, scan index, pending and display registers clear to 0.
  - digit and segment driven to the inactive level (all 1s when ACTIVE_LOW=1).
  - frame_start = 0.
  - Reset asserted mid-frame takes effect on the next edge with no partial outputs.
- Slot counter:
  - free-running SLOT_BITS counter.
  - on wrap, scan index increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
- Scan FSM, per slot:
  - DEAD: counter < DEAD_CYCLES; all digits off; segment inactive.
  - ON: counter[SLOT_BITS-1:SLOT_BITS-4] < brightness; selected digit on.
  - OFF: remainder of the slot; all digits off.
  - Order is always DEAD -> ON -> OFF -> next slot DEAD.
  - brightness=0 stays in DEAD/OFF only.
  - brightness=15 gives ON for 15/16 of the slot minus dead time.
- Loading:
  - load=1 captures value/dp into pending on that edge; repeated loads overwrite.
  - pending copies to display only on the cycle the scan index wraps to 0; frame_start pulses that same cycle.
  - load coincident with the wrap: the new data is captured into pending and shown the following frame.
- Decode:
  - standard hex font 0-F, 7 bits.
  - segment bit 7 = dp[i].
  - decode reads the display register only, never raw value.
- Leading-zero blanking (lz_blank=1):
  - digit i is blanked (segment inactive, digit still scanned) if it and all higher digits are 0 and i != 0.
  - digit 0 is always shown.
  - a set dp disables blanking for that digit and all lower digits.
- Latency:
  - digit/segment are registered, one cycle after the internal counter/index state.
  - brightness changes apply within one cycle (not frame-synced).

Optional Feature:
- SEG_SCAN_BLINK_EN defined:
  - adds input blink_mask[NUM_DIGITS] (frame-synced like value).
  - adds a 6-bit frame counter.
  - digits with the mask bit set are blanked while frame counter bit 5 = 1 (32 on / 32 off frames).
- Undefined: no blink_mask port and no frame counter; behaviour otherwise identical.

Decomposition:
- Package seg_scan_pkg:
  - 16-entry hex font constant.
  - FSM state enum {DEAD, ON, OFF}.
  - segment bit-index constants.
- One sub-module: seg_hex_decode, combinational nibble+dp -> 8-bit active-high pattern; polarity applied in the parent.

Test Plan:
- Reset (NUM_DIGITS=4, SLOT_BITS=6, DEAD_CYCLES=2):
  - after reset release, digit=4'b1111 and segment=8'hFF until the first ON phase.
  - first frame_start after 256 cycles.
- Frame-synced load:
  - load value=16'h12AF mid-frame; the current frame still shows 0000.
  - from the next frame_start, digit0 segment=~8'h71 (F) and digit3 = ~8'h06 (1).
- Leading-zero blanking:
  - value=16'h0030, lz_blank=1: digits 3 and 2 blank, digit1 shows 3, digit0 shows 0.
  - same value with dp[2]=1: digit2 shows 0 with dp.
- Brightness:
  - brightness=0: digit never active over 2 frames.
  - brightness=8: ON phase spans 32-2 = 30 cycles of each 64-cycle slot.
  - brightness=15: ON phase spans 58 cycles.
- Wrap/simultaneous events:
  - load pulsed exactly on the frame_start cycle: data appears at the subsequent frame_start.
  - scan index sequence 0,1,2,3,0 verified.
- Reset mid-ON phase: outputs inactive the next cycle; counters restart from 0; display register cleared.
